// File: rtl/gobang_pkg.sv
// Shared board constants, scan state encoding and cell helpers for the
// directional five-in-a-row scanners.
package gobang_pkg;

    localparam int BOARD_N = 15;
    localparam int WIN_LEN = 5;
    localparam int CELLS   = BOARD_N * BOARD_N;

    typedef enum logic [1:0] {
        IDLE,
        SCAN_UR,
        SCAN_LL,
        DONE
    } scan_state_t;

    // Flat index of cell (r,c); callers gate with in_board first.
    function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        return 8'(int'(r) * BOARD_N + int'(c));
    endfunction

    // True when a signed cursor lies on the board.
    function automatic logic in_board(input logic signed [4:0] r, input logic signed [4:0] c);
        return (r >= 5'sd0) && (int'(r) < BOARD_N) &&
               (c >= 5'sd0) && (int'(c) < BOARD_N);
    endfunction

endpackage

// File: rtl/cell_fetch.sv
// Single-cell lookup into a one-colour occupancy vector. Off-board cursors
// read as empty so a walk stops at the edge without indexing out of range.
module cell_fetch
    import gobang_pkg::*;
(
    input  logic [CELLS-1:0]  ch_q,
    input  logic signed [4:0] r,
    input  logic signed [4:0] c,
    output logic              stone
);

    // Bound test first, then the 225:1 mux.
    always_comb begin
        // NOTE: default assignment first so every path drives stone; no latch.
        stone = 1'b0;
        if (in_board(r, c)) begin
            stone = ch_q[cell_idx(r[3:0], c[3:0])];
        end
    end

endmodule

// File: rtl/upper_right_to_lower_left_scan.sv
// Sequential anti-diagonal (row+col constant) five-in-a-row checker.
// Starting at the placed stone it walks toward the upper-right, then the
// lower-left, one cell per clock, and reports win/err with a done pulse.
module upper_right_to_lower_left_scan
    import gobang_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       row,
    input  logic [3:0]       col,
    input  logic [CELLS-1:0] ch,
    output logic             busy,
    output logic             done,
    output logic             win,
    output logic             err
);

    localparam logic [2:0] WIN_CNT   = 3'(WIN_LEN);
    // Each direction examines at most WIN_LEN-1 cells; steps counts 0..3.
    localparam logic [1:0] LAST_STEP = 2'(WIN_LEN - 2);

    scan_state_t       state, state_nxt;
    logic [3:0]        row_q, col_q;
    logic [CELLS-1:0]  ch_q;
    logic signed [4:0] cur_r, cur_c;
    logic [2:0]        count;
    logic [1:0]        steps;
    logic              win_q, err_q;

    logic placed, stone, bad_pos, reach_win, last_cell, walk_on;

    // Placed-stone lookup on the live input, used only when start is accepted.
    cell_fetch u_placed (
        .ch_q  (ch),
        .r     ($signed({1'b0, row})),
        .c     ($signed({1'b0, col})),
        .stone (placed)
    );

    // Cursor lookup on the snapshot taken at start.
    cell_fetch u_cursor (
        .ch_q  (ch_q),
        .r     (cur_r),
        .c     (cur_c),
        .stone (stone)
    );

    assign bad_pos   = (row > 4'(BOARD_N - 1)) || (col > 4'(BOARD_N - 1));
    assign reach_win = stone && (count == WIN_CNT - 3'd1);
    assign last_cell = (steps == LAST_STEP);
    assign walk_on   = stone && !reach_win && !last_cell;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignment for all clocked state so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (bad_pos || !placed) ? DONE : SCAN_UR;
                end
            end
            SCAN_UR: begin
                if (reach_win)     state_nxt = DONE;
                else if (!walk_on) state_nxt = SCAN_LL;
            end
            SCAN_LL: begin
                if (!walk_on) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    assign win = win_q;
    assign err = err_q;

    // Datapath: snapshot, cursor walk, stone count and held result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            // NOTE: the snapshot is ordinary flops, not RAM, so it takes the
            // async reset like every other register here.
            ch_q  <= '0;
            cur_r <= '0;
            cur_c <= '0;
            count <= '0;
            steps <= '0;
            win_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_q <= row;
                        col_q <= col;
                        ch_q  <= ch;
                        win_q <= 1'b0;
                        err_q <= bad_pos;
                        count <= (!bad_pos && placed) ? 3'd1 : 3'd0;
                        cur_r <= $signed({1'b0, row}) - 5'sd1;
                        cur_c <= $signed({1'b0, col}) + 5'sd1;
                        steps <= '0;
                    end
                end
                SCAN_UR: begin
                    if (stone && count < WIN_CNT) count <= count + 3'd1;
                    if (reach_win) win_q <= 1'b1;
                    if (walk_on) begin
                        cur_r <= cur_r - 5'sd1;
                        cur_c <= cur_c + 5'sd1;
                        steps <= steps + 2'd1;
                    end else begin
                        // Restart just below-left of the placed stone.
                        cur_r <= $signed({1'b0, row_q}) + 5'sd1;
                        cur_c <= $signed({1'b0, col_q}) - 5'sd1;
                        steps <= '0;
                    end
                end
                SCAN_LL: begin
                    if (stone && count < WIN_CNT) count <= count + 3'd1;
                    if (reach_win) win_q <= 1'b1;
                    if (walk_on) begin
                        cur_r <= cur_r + 5'sd1;
                        cur_c <= cur_c - 5'sd1;
                        steps <= steps + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_upper_right_to_lower_left_scan.sv
// Directed bench for the anti-diagonal scanner: latency, win/err results,
// board-edge stops, back-to-back starts, mid-scan reset and snapshot isolation.
module tb_upper_right_to_lower_left_scan;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   row, col;
    logic [224:0] ch;
    logic         busy, done, win, err;

    int checks = 0;
    int errors = 0;

    upper_right_to_lower_left_scan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .row   (row),
        .col   (col),
        .ch    (ch),
        .busy  (busy),
        .done  (done),
        .win   (win),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: asserts start there, then counts cycles to done.
    task automatic run(input logic [3:0] r, input logic [3:0] c, input logic [224:0] v,
                       input int exp_n, input logic exp_win, input logic exp_err,
                       input logic disturb, input string tag);
        int n;
        start = 1'b1;
        row   = r;
        col   = c;
        ch    = v;
        @(negedge clk);
        n     = 1;
        start = disturb;
        if (disturb) ch = '1;
        check({tag, " busy"}, 32'(busy), 32'd1);
        while (!done && n < 30) begin
            if (disturb) begin
                start = (n < 3);
                ch    = n[0] ? '0 : '1;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(exp_n));
        check({tag, " win"}, 32'(win), 32'(exp_win));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " win held"}, 32'(win), 32'(exp_win));
    endtask

    logic [224:0] b1, b2, b3, b4;

    initial begin
        b1 = '0; b1[112] = 1'b1; b1[98] = 1'b1; b1[84] = 1'b1; b1[70] = 1'b1; b1[56] = 1'b1;
        b2 = '0; b2[14]  = 1'b1; b2[28] = 1'b1; b2[42] = 1'b1; b2[56] = 1'b1; b2[70] = 1'b1;
        b3 = '0; b3[3]   = 1'b1; b3[17] = 1'b1; b3[31] = 1'b1; b3[45] = 1'b1;
        b4 = '0; b4[112] = 1'b1; b4[98] = 1'b1; b4[84] = 1'b1; b4[70] = 1'b1;

        rst_n = 1'b0;
        start = 1'b0;
        row   = '0;
        col   = '0;
        ch    = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset win",  32'(win),  32'd0);
        check("reset err",  32'(err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Five up-right from (7,7): LL skipped, done in cycle 5.
        run(4'd7, 4'd7, b1, 5, 1'b1, 1'b0, 1'b0, "ur_five");
        // (2,12): UR stops at top edge after 2 stones, LL adds 2.
        run(4'd2, 4'd12, b2, 6, 1'b1, 1'b0, 1'b0, "edge_split");
        // Full short diagonal row+col=3: only 4 cells, never a win.
        run(4'd1, 4'd2, b3, 6, 1'b0, 1'b0, 1'b0, "short_diag");
        // Four in a row only, then an immediate back-to-back start.
        run(4'd7, 4'd7, b4, 6, 1'b0, 1'b0, 1'b0, "four_only");
        run(4'd7, 4'd7, b1, 5, 1'b1, 1'b0, 1'b0, "back_to_back");
        // Out-of-range coordinates and empty placed cell.
        run(4'd15, 4'd0, b1, 1, 1'b0, 1'b1, 1'b0, "row_err");
        run(4'd3, 4'd15, b1, 1, 1'b0, 1'b1, 1'b0, "col_err");
        run(4'd0, 4'd0, b1, 1, 1'b0, 1'b0, 1'b0, "empty_cell");

        // Reset in the middle of SCAN_UR.
        start = 1'b1;
        row   = 4'd7;
        col   = 4'd7;
        ch    = b1;
        @(negedge clk);
        start = 1'b0;
        check("midscan busy before", 32'(busy), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midscan rst busy", 32'(busy), 32'd0);
        check("midscan rst done", 32'(done), 32'd0);
        check("midscan rst win",  32'(win),  32'd0);
        check("midscan rst err",  32'(err),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(4'd2, 4'd12, b2, 6, 1'b1, 1'b0, 1'b0, "after_reset");

        // ch and start toggled while busy must not change the result.
        run(4'd7, 4'd7, b1, 5, 1'b1, 1'b0, 1'b1, "disturb");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
